// File: rtl/mult_product_accumulator.sv
// Accumulates a stream of unsigned multiplier products into groups and presents
// each group's sum, term count and sticky carry-out flag over a valid/ready handshake.
module mult_product_accumulator #(
   parameter int PROD_W    = 8,
   parameter int ACC_W     = 16,
   parameter int MAX_TERMS = 16,
   parameter int COUNT_W   = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [PROD_W-1:0]  in_product_i,
   input  logic               in_last_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [ACC_W-1:0]   out_sum_o,
   output logic [COUNT_W-1:0] out_count_o,
   output logic               out_overflow_o
);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t             state_q;
   logic [ACC_W-1:0]   acc_q;
   logic [COUNT_W-1:0] cnt_q;
   logic               ovf_q;
   logic               out_valid_q;
   logic [ACC_W-1:0]   out_sum_q;
   logic [COUNT_W-1:0] out_count_q;
   logic               out_overflow_q;

   logic [ACC_W:0]     sum_d;
   logic [COUNT_W-1:0] cnt_d;
   logic               ovf_d;
   logic               accept_d;
   logic               close_d;

   // One extra bit on the adder captures the carry out of the accumulator.
   always_comb begin
      sum_d    = {1'b0, acc_q} + {{(ACC_W - PROD_W + 1){1'b0}}, in_product_i};
      cnt_d    = cnt_q + 1'b1;
      ovf_d    = ovf_q | sum_d[ACC_W];
      accept_d = in_valid_i & (state_q == ACCUM);
      close_d  = accept_d & (in_last_i | (cnt_d == COUNT_W'(MAX_TERMS)));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ACCUM;
         acc_q          <= '0;
         cnt_q          <= '0;
         ovf_q          <= 1'b0;
         out_valid_q    <= 1'b0;
         out_sum_q      <= '0;
         out_count_q    <= '0;
         out_overflow_q <= 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (close_d) begin
                  out_sum_q      <= sum_d[ACC_W-1:0];
                  out_count_q    <= cnt_d;
                  out_overflow_q <= ovf_d;
                  out_valid_q    <= 1'b1;
                  acc_q          <= '0;
                  cnt_q          <= '0;
                  ovf_q          <= 1'b0;
                  state_q        <= HOLD;
               end else if (accept_d) begin
                  acc_q <= sum_d[ACC_W-1:0];
                  cnt_q <= cnt_d;
                  ovf_q <= ovf_d;
               end
            end
            HOLD: begin
               // Result registers keep their contents after the handshake.
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ACCUM;
               end
            end
            default: state_q <= ACCUM;
         endcase
      end
   end

   assign in_ready_o     = (state_q == ACCUM);
   assign out_valid_o    = out_valid_q;
   assign out_sum_o      = out_sum_q;
   assign out_count_o    = out_count_q;
   assign out_overflow_o = out_overflow_q;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Directed bench: one default instance and one ACC_W=10 instance share the same
// input stream so the narrow accumulator can exercise wrap and overflow.
module tb_mult_product_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_product;
   logic        in_last;
   logic        out_ready;

   logic        in_ready_a, out_valid_a, out_overflow_a;
   logic [15:0] out_sum_a;
   logic [4:0]  out_count_a;

   logic        in_ready_b, out_valid_b, out_overflow_b;
   logic [9:0]  out_sum_b;
   logic [4:0]  out_count_b;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mult_product_accumulator dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready_a),
      .in_product_i(in_product), .in_last_i(in_last),
      .out_valid_o(out_valid_a), .out_ready_i(out_ready),
      .out_sum_o(out_sum_a), .out_count_o(out_count_a),
      .out_overflow_o(out_overflow_a)
   );

   mult_product_accumulator #(.ACC_W(10)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready_b),
      .in_product_i(in_product), .in_last_i(in_last),
      .out_valid_o(out_valid_b), .out_ready_i(out_ready),
      .out_sum_o(out_sum_b), .out_count_o(out_count_b),
      .out_overflow_o(out_overflow_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] p, input logic l);
      in_valid   = v;
      in_product = p;
      in_last    = l;
   endtask

   initial begin
      rst_n = 1'b0; out_ready = 1'b0;
      drive(1'b1, 8'hFF, 1'b0);

      // Reset with a product pending: nothing may be absorbed.
      step(); step();
      chk("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
      rst_n = 1'b1;
      drive(1'b0, 8'd0, 1'b0);
      step();
      chk("rst_rel_out_valid", {31'd0, out_valid_a}, 32'd0);
      chk("rst_rel_in_ready", {31'd0, in_ready_a}, 32'd1);
      chk("rst_rel_out_sum", {16'd0, out_sum_a}, 32'd0);
      chk("rst_rel_out_count", {27'd0, out_count_a}, 32'd0);

      // Basic group 10+20+30.
      out_ready = 1'b1;
      drive(1'b1, 8'd10, 1'b0); step();
      chk("basic_mid_valid", {31'd0, out_valid_a}, 32'd0);
      drive(1'b1, 8'd20, 1'b0); step();
      drive(1'b1, 8'd30, 1'b1); step();
      chk("basic_valid", {31'd0, out_valid_a}, 32'd1);
      chk("basic_sum", {16'd0, out_sum_a}, 32'd60);
      chk("basic_count", {27'd0, out_count_a}, 32'd3);
      chk("basic_ovf", {31'd0, out_overflow_a}, 32'd0);
      chk("basic_in_ready_hold", {31'd0, in_ready_a}, 32'd0);
      drive(1'b0, 8'd0, 1'b0); step();
      chk("basic_after_valid", {31'd0, out_valid_a}, 32'd0);
      chk("basic_after_in_ready", {31'd0, in_ready_a}, 32'd1);

      // Backpressure: 225+225 held while a 7 is offered.
      out_ready = 1'b0;
      drive(1'b1, 8'd225, 1'b0); step();
      drive(1'b1, 8'd225, 1'b1); step();
      drive(1'b1, 8'd7, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", {31'd0, out_valid_a}, 32'd1);
         chk("bp_sum", {16'd0, out_sum_a}, 32'd450);
         chk("bp_count", {27'd0, out_count_a}, 32'd2);
         chk("bp_in_ready", {31'd0, in_ready_a}, 32'd0);
         chk("bp_sum_narrow", {22'd0, out_sum_b}, 32'd450);
         step();
      end
      out_ready = 1'b1;
      drive(1'b0, 8'd0, 1'b0); step();
      chk("bp_release_valid", {31'd0, out_valid_a}, 32'd0);
      drive(1'b1, 8'd4, 1'b1); step();
      chk("bp_next_sum", {16'd0, out_sum_a}, 32'd4);
      chk("bp_next_count", {27'd0, out_count_a}, 32'd1);
      drive(1'b0, 8'd0, 1'b0); step();

      // Auto-close after 16 terms.
      drive(1'b1, 8'd1, 1'b0);
      for (int i = 0; i < 15; i++) step();
      chk("auto_15_valid", {31'd0, out_valid_a}, 32'd0);
      step();
      chk("auto_valid", {31'd0, out_valid_a}, 32'd1);
      chk("auto_sum", {16'd0, out_sum_a}, 32'd16);
      chk("auto_count", {27'd0, out_count_a}, 32'd16);
      step();
      chk("auto_handshake_valid", {31'd0, out_valid_a}, 32'd0);
      drive(1'b1, 8'd1, 1'b1); step();
      chk("auto_17_sum", {16'd0, out_sum_a}, 32'd1);
      chk("auto_17_count", {27'd0, out_count_a}, 32'd1);
      drive(1'b0, 8'd0, 1'b0); step();

      // Overflow on the 10-bit instance: 5*225 = 1125.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'd225, (i == 4));
         step();
      end
      chk("ovf_sum_narrow", {22'd0, out_sum_b}, 32'd101);
      chk("ovf_count_narrow", {27'd0, out_count_b}, 32'd5);
      chk("ovf_flag_narrow", {31'd0, out_overflow_b}, 32'd1);
      chk("ovf_sum_wide", {16'd0, out_sum_a}, 32'd1125);
      chk("ovf_flag_wide", {31'd0, out_overflow_a}, 32'd0);
      drive(1'b0, 8'd0, 1'b0); step();
      drive(1'b1, 8'd1, 1'b1); step();
      chk("ovf_next_sum", {22'd0, out_sum_b}, 32'd1);
      chk("ovf_next_flag", {31'd0, out_overflow_b}, 32'd0);
      drive(1'b0, 8'd0, 1'b0); step();

      // Mid-group reset with a bubble.
      drive(1'b1, 8'd5, 1'b0); step();
      drive(1'b0, 8'd0, 1'b0); step();
      drive(1'b1, 8'd6, 1'b0); step();
      drive(1'b0, 8'd0, 1'b0); rst_n = 1'b0; step();
      chk("midrst_valid", {31'd0, out_valid_a}, 32'd0);
      chk("midrst_sum", {16'd0, out_sum_a}, 32'd0);
      rst_n = 1'b1;
      drive(1'b1, 8'd9, 1'b1); step();
      chk("midrst_new_valid", {31'd0, out_valid_a}, 32'd1);
      chk("midrst_new_sum", {16'd0, out_sum_a}, 32'd9);
      chk("midrst_new_count", {27'd0, out_count_a}, 32'd1);
      drive(1'b0, 8'd0, 1'b0); step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
